// File: rtl/pipe_skid_reg.sv
// Pipeline boundary register with a valid/ready handshake, a 2-entry skid buffer and bubble/stall controls.
// Optional stall-cycle counter output perf_stall_cnt when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
   parameter int               WIDTH   = 128,
   parameter logic [WIDTH-1:0] DEFAULT = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bubble,
   input  logic             stall,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt
`endif
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             in_ready_q, in_ready_d;
   logic             accept_s;
   logic             drain_s;

   assign accept_s = in_valid & in_ready_q & ~bubble;
   assign drain_s  = out_valid_q & out_ready & ~stall;

   // Next-state of main and skid entries; skid always drains into main before new input.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (bubble) begin
         out_valid_d  = 1'b0;
         out_data_d   = DEFAULT;
         skid_valid_d = 1'b0;
         skid_data_d  = DEFAULT;
      end else if (!out_valid_q) begin
         if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
            out_data_d  = DEFAULT;
         end
      end else if (drain_s) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = DEFAULT;
         end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
            out_data_d  = DEFAULT;
         end
      end else begin
         if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
         end
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers; ready is registered so out_ready/stall never reach in_ready combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= DEFAULT;
         skid_valid_q <= 1'b0;
         skid_data_q  <= DEFAULT;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef PIPE_SKID_PERF_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;

   // Saturating count of cycles where held data is not consumed; bubble cycles excluded.
   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (out_valid_q && (!out_ready || stall) && !bubble && (perf_cnt_q != 32'hFFFF_FFFF)) begin
         perf_cnt_d = perf_cnt_q + 32'd1;
      end else begin
         perf_cnt_d = perf_cnt_q;
      end
   end

   // Counter register; cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt_q <= 32'd0;
      end else begin
         perf_cnt_q <= perf_cnt_d;
      end
   end

   assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_pipe_skid_reg;
   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         bubble, stall, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
   logic [31:0]  perf_stall_cnt;
`endif

   int nvec = 0;
   int nmis = 0;

   // Reference model: a 2-deep FIFO; head is what downstream sees.
   logic [W-1:0] mq[$];
   logic [31:0]  mperf;

   pipe_skid_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .bubble(bubble), .stall(stall),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PIPE_SKID_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         b, s, iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         ev;
      logic [W-1:0] ed;
      logic         er;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input logic b, s, iv, input logic [W-1:0] d, input logic ordy,
                      input logic ev, input logic [W-1:0] ed, input logic er);
      vec_t v;
      v.b = b; v.s = s; v.iv = iv; v.d = d; v.ordy = ordy;
      v.ev = ev; v.ed = ed; v.er = er;
      tbl.push_back(v);
   endtask

   task automatic model_update(input logic b, s, iv, ordy, input logic [W-1:0] d);
      bit drain, acc;
      if (mq.size() > 0 && (!ordy || s) && !b && mperf != 32'hFFFF_FFFF) mperf = mperf + 32'd1;
      if (b) begin
         mq.delete();
      end else begin
         drain = (mq.size() > 0) && ordy && !s;
         acc   = iv && (mq.size() < 2);
         if (drain) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
   endtask

   task automatic step(input logic b, s, iv, input logic [W-1:0] d, input logic ordy);
      bubble = b; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
      @(posedge clk);
      model_update(b, s, iv, ordy, d);
      #1;
   endtask

   task automatic chk_model(input string tag);
      logic [W-1:0] ed;
      ed = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, ".out_valid"}, {127'd0, out_valid}, {127'd0, mq.size() > 0});
      chk({tag, ".out_data"}, out_data, ed);
      chk({tag, ".in_ready"}, {127'd0, in_ready}, {127'd0, mq.size() < 2});
`ifdef PIPE_SKID_PERF_EN
      chk({tag, ".perf"}, {96'd0, perf_stall_cnt}, {96'd0, mperf});
`endif
   endtask

   task automatic do_reset();
      bubble = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      rst = 1'b1;
      #7;
      rst = 1'b0;
      mq.delete();
      mperf = 32'd0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      bubble = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      mq.delete();
      mperf = 32'd0;
      #3;
      chk("reset.out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset.out_data", out_data, 128'd0);
      chk("reset.in_ready", {127'd0, in_ready}, 128'd1);
      do_reset();

      // b s iv data ordy | out_valid out_data in_ready (after the edge)
      add(0,0,1,128'h1,1, 1,128'h1,1);
      add(0,0,1,128'h2,1, 1,128'h2,1);
      add(0,0,1,128'h3,1, 1,128'h3,1);
      add(0,0,1,128'h4,1, 1,128'h4,1);
      add(0,0,0,128'h0,1, 0,128'h0,1);
      add(0,0,1,128'hA,0, 1,128'hA,1);
      add(0,0,1,128'hB,0, 1,128'hA,0);
      add(0,0,1,128'hC,0, 1,128'hA,0);
      add(0,0,1,128'hC,1, 1,128'hB,1);
      add(0,0,1,128'hC,1, 1,128'hC,1);
      add(0,0,0,128'h0,1, 0,128'h0,1);
      add(0,0,1,128'h55,1, 1,128'h55,1);
      add(0,1,0,128'h0,1, 1,128'h55,1);
      add(0,1,0,128'h0,1, 1,128'h55,1);
      add(0,1,0,128'h0,1, 1,128'h55,1);
      add(0,0,0,128'h0,1, 0,128'h0,1);
      add(0,0,1,128'h11,0, 1,128'h11,1);
      add(0,0,1,128'h22,0, 1,128'h11,0);
      add(1,1,1,128'h33,0, 0,128'h0,1);
      add(0,0,0,128'h0,1, 0,128'h0,1);
      foreach (tbl[i]) begin
         step(tbl[i].b, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         chk($sformatf("vec%0d.out_valid", i), {127'd0, out_valid}, {127'd0, tbl[i].ev});
         chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].ed);
         chk($sformatf("vec%0d.in_ready", i), {127'd0, in_ready}, {127'd0, tbl[i].er});
      end

      // Asynchronous reset with both entries full, checked before any clock edge.
      do_reset();
      step(1'b0, 1'b0, 1'b1, {4{32'hDEAD_BEEF}}, 1'b0);
      step(1'b0, 1'b0, 1'b1, {4{32'hCAFE_F00D}}, 1'b0);
      chk("prerst.in_ready", {127'd0, in_ready}, 128'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("asyncrst.out_valid", {127'd0, out_valid}, 128'd0);
      chk("asyncrst.out_data", out_data, 128'd0);
      chk("asyncrst.in_ready", {127'd0, in_ready}, 128'd1);
      do_reset();

`ifdef PIPE_SKID_PERF_EN
      // Five held cycles then a bubble: counter keeps 5.
      step(1'b0, 1'b0, 1'b1, 128'h7, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 128'h0, 1'b0);
      chk("perf.after_bubble", {96'd0, perf_stall_cnt}, 128'd5);
      do_reset();
`endif

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) != 0);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
